// File: rtl/tdm_demux8.sv
// Eight-slot TDM demultiplexer: aligns on frame_start, stages words
// and publishes complete frames on a held, acknowledged out register.
module tdm_demux8 #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   in,
  input  logic               in_valid,
  input  logic               frame_start,
  output logic [8*WIDTH-1:0] out,
  output logic               out_valid,
  input  logic               out_ack,
  output logic [2:0]         slot,
  output logic               sync_err,
  output logic               overrun
);

  typedef enum logic {
    HUNT,
    COLLECT
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [2:0]         slot_q;
  logic [2:0]         slot_d;
  logic [WIDTH-1:0]   stage_q [8];
  logic               wr_en;
  logic [2:0]         wr_idx;
  logic               complete;
  logic               restart;
  logic [8*WIDTH-1:0] frame;
  logic [8*WIDTH-1:0] out_q;
  logic               out_valid_q;
  logic               sync_err_q;
  logic               overrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    wr_en    = 1'b0;
    wr_idx   = slot_q;
    complete = 1'b0;
    restart  = 1'b0;
    if (in_valid) begin
      unique case (1'b1)
        frame_start: begin
          restart = (state_q == COLLECT);
          wr_en   = 1'b1;
          wr_idx  = 3'd0;
          slot_d  = 3'd1;
          state_d = COLLECT;
        end
        (!frame_start && state_q == COLLECT): begin
          wr_en  = 1'b1;
          slot_d = 3'(slot_q + 3'd1);
          if (slot_q == 3'd7) begin
            complete = 1'b1;
            state_d  = HUNT;
          end
        end
        default: ;
      endcase
    end
  end

  // slot 7 bypasses staging so the frame lands on out the same edge
  always_comb begin
    frame = '0;
    for (int k = 0; k < 7; k++) begin
      frame[k*WIDTH +: WIDTH] = stage_q[k];
    end
    frame[7*WIDTH +: WIDTH] = in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) begin
        stage_q[k] <= '0;
      end
    end else if (wr_en) begin
      stage_q[wr_idx] <= in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_err_q <= restart;
      overrun_q  <= complete && out_valid_q && !out_ack;
      if (complete) begin
        out_q       <= frame;
        out_valid_q <= 1'b1;
      end else if (out_ack && out_valid_q) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign slot      = slot_q;
  assign sync_err  = sync_err_q;
  assign overrun   = overrun_q;

endmodule
